// File: rtl/mips_cpu_bus_mem_if.sv
// Avalon-MM memory interface for the multicycle MIPS core: one request at a time, lane steering,
// load extension, misalignment check and optional waitrequest timeout.
module mips_cpu_bus_mem_if #(
    parameter int unsigned WAIT_LIMIT  = 0,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, RDATA, RESP} state_t;

    state_t      state, stateNext;
    logic [1:0]  addrLo;
    logic [1:0]  sizeQ;
    logic        signedQ;
    logic        writeQ;
    logic [31:0] waitCnt;

    logic        accept;
    logic        reqErr;
    logic        timeout;
    logic [1:0]  reqLane;
    logic [3:0]  beNext;
    logic [31:0] wdNext;
    logic [1:0]  rspLane;
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;
    logic [31:0] loadData;

    assign accept = req_valid & req_ready;

    always_comb begin
        reqErr = 1'b0;
        if (req_size == 2'b11)
            reqErr = 1'b1;
        else if (ALIGN_CHECK && (((req_size == 2'b01) && req_addr[0]) ||
                                 ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))))
            reqErr = 1'b1;
    end

    // The counter value is the number of stalled cycles already seen, so the
    // bus request stays up for exactly WAIT_LIMIT cycles before aborting.
    assign timeout = (WAIT_LIMIT != 0) && waitrequest && ((waitCnt + 32'd1) == WAIT_LIMIT);

    // Lane index: ignored low bits are dropped when ALIGN_CHECK is off.
    always_comb begin
        reqLane = 2'b00;
        beNext  = 4'b1111;
        wdNext  = req_wdata;
        case (req_size)
            2'b00: begin
                reqLane = req_addr[1:0];
                beNext  = 4'b0001 << reqLane;
                wdNext  = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                reqLane = {req_addr[1], 1'b0};
                beNext  = 4'b0011 << reqLane;
                wdNext  = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        rspLane  = (sizeQ == 2'b01) ? {addrLo[1], 1'b0} : addrLo;
        loadByte = readdata[{rspLane, 3'b000} +: 8];
        loadHalf = readdata[{rspLane[1], 4'b0000} +: 16];
        case (sizeQ)
            2'b00:   loadData = {{24{signedQ & loadByte[7]}}, loadByte};
            2'b01:   loadData = {{16{signedQ & loadHalf[15]}}, loadHalf};
            default: loadData = readdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:
                if (accept)
                    stateNext = reqErr ? RESP : ISSUE;
            ISSUE:
                if (!waitrequest)
                    stateNext = writeQ ? RESP : RDATA;
                else if (timeout)
                    stateNext = RESP;
            RDATA:   stateNext = RESP;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE) && !reset;
        read      = (state == ISSUE) && !writeQ;
        write     = (state == ISSUE) && writeQ;
        rsp_valid = (state == RESP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addrLo     <= 2'b00;
            sizeQ      <= 2'b00;
            signedQ    <= 1'b0;
            writeQ     <= 1'b0;
            waitCnt    <= 32'd0;
            address    <= 32'd0;
            byteenable <= 4'b0000;
            writedata  <= 32'd0;
            rsp_rdata  <= 32'd0;
            rsp_error  <= 1'b0;
        end else begin
            case (state)
                IDLE:
                    if (accept) begin
                        addrLo     <= req_addr[1:0];
                        sizeQ      <= req_size;
                        signedQ    <= req_signed;
                        writeQ     <= req_write;
                        waitCnt    <= 32'd0;
                        address    <= {req_addr[31:2], 2'b00};
                        byteenable <= beNext;
                        writedata  <= wdNext;
                        rsp_rdata  <= 32'd0;
                        rsp_error  <= reqErr;
                    end
                ISSUE:
                    if (waitrequest && (WAIT_LIMIT != 0)) begin
                        waitCnt <= waitCnt + 32'd1;
                        if (timeout)
                            rsp_error <= 1'b1;
                    end
                RDATA:
                    rsp_rdata <= loadData;
                default: ;
            endcase
        end
    end

endmodule
